multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle control FSM that sequences the register file / ALU / data memory / sign-extend datapath for a MIPS subset.
- Accepts one 32-bit instruction per valid/ready handshake, then steps it through decode, execute, memory and writeback.
- Drives every datapath control line and flags illegal opcodes and datapath errors.
- Maintains a retired-instruction counter.

Parameters:
- COUNT_WIDTH, 32, width of retired-instruction counter (wraps modulo 2^COUNT_WIDTH)

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- instr  in  32  instruction word
- instr_valid  in  1  instr is valid this cycle
- instr_ready  out  1  controller can accept an instruction
- alu_err_overflow  in  1  overflow flag from ALU, sampled in EXECUTE
- mem_err_invalid_address  in  1  address error from data memory, sampled in MEMORY
- err_clear  in  1  leave ERROR state
- rs_addr  out  5  register read address A (IR[25:21])
- rt_addr  out  5  register read address B (IR[20:16])
- write_addr  out  5  register write address
- reg_write  out  1  register file write enable
- imm  out  16  immediate field (IR[15:0]) to sign extender
- alu_src_imm  out  1  1: ALU B = sign-extended imm; 0: register B
- alu_control  out  2  00 add, 01 sub, 10 and, 11 or
- mem_read  out  1  data memory read enable
- mem_write  out  1  data memory write enable
- mem_to_reg  out  1  1: writeback data from memory; 0: from ALU result
- instr_done  out  1  one-cycle pulse when an instruction retires
- err_illegal  out  1  high in ERROR when the cause was an illegal instruction
- err_datapath  out  1  high in ERROR when the cause was overflow or bad address
- retired_count  out  COUNT_WIDTH  number of retired instructions

Behaviour:
- Reset (async, reset_n=0):
  - state=FETCH, IR=0, retired_count=0, error flags=0.
  - All enables (reg_write, mem_read, mem_write, instr_done) are 0. instr_ready=1 once reset_n is released.
  - Reset mid-instruction abandons the instruction; no partial write occurs after reset asserts.
- States: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, ERROR. Outputs are Moore, decoded from state and the registered IR.
- FETCH:
  - instr_ready=1.
  - If instr_valid=1 at the clock edge, latch IR=instr and go to DECODE. Otherwise stay.
- DECODE:
  - rs_addr/rt_addr are valid from IR.
  - Legal instructions:
    - opcode 0x00 with funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or
    - opcode 0x08 addi
    - opcode 0x23 lw
    - opcode 0x2B sw
  - Anything else sets err_illegal and goes to ERROR. Otherwise go to EXECUTE.
- EXECUTE:
  - alu_control comes from funct for R-type; add for addi/lw/sw.
  - alu_src_imm=1 for addi/lw/sw.
  - If alu_err_overflow=1 and the op is add, sub or addi: set err_datapath, go to ERROR, no writeback.
  - Otherwise R-type/addi go to WRITEBACK; lw/sw go to MEMORY.
- MEMORY:
  - lw: mem_read=1.
  - sw: mem_write=1 and instr_done=1, then go to FETCH.
  - If mem_err_invalid_address=1: set err_datapath, go to ERROR, no retire.
  - Otherwise lw goes to WRITEBACK.
- WRITEBACK:
  - reg_write=1.
  - write_addr = IR[15:11] for R-type, IR[20:16] for addi/lw.
  - mem_to_reg=1 for lw.
  - instr_done=1, then go to FETCH.
- write_addr is 0 outside WRITEBACK. alu_control, alu_src_imm and mem_to_reg hold their decoded values in every state after FETCH.
- Latency from the accept edge to the retire cycle:
  - R-type/addi: 3 cycles (DECODE, EXECUTE, WRITEBACK)
  - lw: 4 cycles
  - sw: 3 cycles
  - Back-to-back instructions are accepted in the cycle immediately after retire.
- retired_count increments by 1 on each clock edge where instr_done=1, wrapping at 2^COUNT_WIDTH-1 to 0.
- ERROR:
  - All enables are 0 and instr_ready=0.
  - Sticky until err_clear=1 at a clock edge; then clear the error flags and go to FETCH. err_clear is ignored in other states.
- A write to register 0 is issued as decoded; the register file owns the r0 semantics.

Decomposition:
- Shared package/include holds the constants below. The datapath top and the testbench reuse them.
  - opcode constants OP_RTYPE, OP_ADDI, OP_LW, OP_SW
  - funct constants FN_ADD, FN_SUB, FN_AND, FN_OR
  - ALU_ADD/SUB/AND/OR 2-bit codes
  - state encoding
- One natural sub-module: instr_decode. It is combinational: IR in, and out come is_rtype/is_addi/is_lw/is_sw/illegal, alu_control and write-address select.
- The FSM, IR and counter stay in multicycle_control.

Test Plan:
- Reset, then present add $3,$1,$2 (0x00221820) with valid → accept in FETCH; reg_write=1 with write_addr=3, alu_control=00 exactly 3 cycles later; instr_done pulse; retired_count=1.
- lw $5,8($4) (0x8C850008) → mem_read=1 in cycle 3 with alu_src_imm=1; reg_write=1, mem_to_reg=1, write_addr=5 in cycle 4.
- sw $5,4($4) (0xAC850004) → mem_write=1 and instr_done=1 in cycle 3; reg_write never asserts; next instruction is accepted the following cycle.
- Opcode 0x3F → ERROR after DECODE with err_illegal=1; instr_ready=0 until err_clear pulses; then FETCH with retired_count unchanged.
- addi with alu_err_overflow=1 in EXECUTE → ERROR with err_datapath=1 and no reg_write. A separate lw with mem_err_invalid_address=1 in MEMORY → ERROR with no writeback.
- Assert reset_n=0 during EXECUTE of sub → all outputs return to reset values immediately; no reg_write afterwards. With COUNT_WIDTH=2, retire 5 instructions → retired_count=1.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared constants and state encoding for the multi-cycle MIPS-subset controller.
package multicycle_control_pkg;

    // Opcode field IR[31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Funct field IR[5:0] for R-type
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;

    // ALU operation codes
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_ERROR
    } state_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Instruction handshake plus datapath control/status bundle of the controller.
interface multicycle_control_if #(
    parameter int COUNT_WIDTH = 32
);
    logic [31:0]            instr;
    logic                   instr_valid;
    logic                   instr_ready;
    logic                   alu_err_overflow;
    logic                   mem_err_invalid_address;
    logic                   err_clear;
    logic [4:0]             rs_addr;
    logic [4:0]             rt_addr;
    logic [4:0]             write_addr;
    logic                   reg_write;
    logic [15:0]            imm;
    logic                   alu_src_imm;
    logic [1:0]             alu_control;
    logic                   mem_read;
    logic                   mem_write;
    logic                   mem_to_reg;
    logic                   instr_done;
    logic                   err_illegal;
    logic                   err_datapath;
    logic [COUNT_WIDTH-1:0] retired_count;

    // Instruction source / datapath side
    modport master (
        output instr, instr_valid, alu_err_overflow, mem_err_invalid_address, err_clear,
        input  instr_ready, rs_addr, rt_addr, write_addr, reg_write, imm, alu_src_imm,
               alu_control, mem_read, mem_write, mem_to_reg, instr_done,
               err_illegal, err_datapath, retired_count
    );

    // Controller side
    modport slave (
        input  instr, instr_valid, alu_err_overflow, mem_err_invalid_address, err_clear,
        output instr_ready, rs_addr, rt_addr, write_addr, reg_write, imm, alu_src_imm,
               alu_control, mem_read, mem_write, mem_to_reg, instr_done,
               err_illegal, err_datapath, retired_count
    );
endinterface

// File: rtl/multicycle_control_instr_decode.sv
// Combinational instruction classifier: op class, ALU op, B-source and write register.
module instr_decode
    import multicycle_control_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    input  logic [4:0] i_rt,
    input  logic [4:0] i_rd,
    output logic       o_is_lw,
    output logic       o_is_sw,
    output logic       o_illegal,
    output logic       o_ovf_check,   // op traps on signed overflow (add/sub/addi)
    output logic       o_alu_src_imm,
    output logic [1:0] o_alu_control,
    output logic [4:0] o_write_addr
);

    // Decode opcode/funct into control classes; anything unlisted is illegal
    always_comb begin
        o_is_lw       = 1'b0;
        o_is_sw       = 1'b0;
        o_illegal     = 1'b0;
        o_ovf_check   = 1'b0;
        o_alu_src_imm = 1'b0;
        o_alu_control = ALU_ADD;
        o_write_addr  = i_rt;
        case (i_opcode)
            OP_RTYPE: begin
                o_write_addr = i_rd;
                case (i_funct)
                    FN_ADD: begin o_alu_control = ALU_ADD; o_ovf_check = 1'b1; end
                    FN_SUB: begin o_alu_control = ALU_SUB; o_ovf_check = 1'b1; end
                    FN_AND: o_alu_control = ALU_AND;
                    FN_OR:  o_alu_control = ALU_OR;
                    default: o_illegal = 1'b1;
                endcase
            end
            OP_ADDI: begin
                o_alu_src_imm = 1'b1;
                o_ovf_check   = 1'b1;
            end
            OP_LW: begin
                o_alu_src_imm = 1'b1;
                o_is_lw       = 1'b1;
            end
            OP_SW: begin
                o_alu_src_imm = 1'b1;
                o_is_sw       = 1'b1;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/ERROR sequencing,
// instruction register, sticky error flags and retired-instruction counter.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,
    multicycle_control_if.slave  bus
);

    state_t                 r_state;
    state_t                 w_next;
    logic [31:0]            r_ir;
    logic                   r_err_illegal;
    logic                   r_err_datapath;
    logic [COUNT_WIDTH-1:0] r_count;

    logic                   w_is_lw;
    logic                   w_is_sw;
    logic                   w_illegal;
    logic                   w_ovf_check;
    logic                   w_alu_src_imm;
    logic [1:0]             w_alu_control;
    logic [4:0]             w_write_addr;
    logic                   w_set_illegal;
    logic                   w_set_datapath;
    logic                   w_done;

    instr_decode u_decode (
        .i_opcode      (r_ir[31:26]),
        .i_funct       (r_ir[5:0]),
        .i_rt          (r_ir[20:16]),
        .i_rd          (r_ir[15:11]),
        .o_is_lw       (w_is_lw),
        .o_is_sw       (w_is_sw),
        .o_illegal     (w_illegal),
        .o_ovf_check   (w_ovf_check),
        .o_alu_src_imm (w_alu_src_imm),
        .o_alu_control (w_alu_control),
        .o_write_addr  (w_write_addr)
    );

    // Next-state selection and error-cause capture
    always_comb begin
        w_next         = r_state;
        w_set_illegal  = 1'b0;
        w_set_datapath = 1'b0;
        case (r_state)
            S_FETCH:     if (bus.instr_valid) w_next = S_DECODE;
            S_DECODE: begin
                if (w_illegal) begin
                    w_next        = S_ERROR;
                    w_set_illegal = 1'b1;
                end else begin
                    w_next = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (bus.alu_err_overflow && w_ovf_check) begin
                    w_next         = S_ERROR;
                    w_set_datapath = 1'b1;
                end else if (w_is_lw || w_is_sw) begin
                    w_next = S_MEMORY;
                end else begin
                    w_next = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                if (bus.mem_err_invalid_address) begin
                    w_next         = S_ERROR;
                    w_set_datapath = 1'b1;
                end else if (w_is_lw) begin
                    w_next = S_WRITEBACK;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_WRITEBACK: w_next = S_FETCH;
            S_ERROR:     if (bus.err_clear) w_next = S_FETCH;
            default:     w_next = S_FETCH;
        endcase
    end

    // State register and instruction latch on the accept edge
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_FETCH;
            r_ir    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH && bus.instr_valid) r_ir <= bus.instr;
        end
    end

    // Sticky error flags, set on entry to ERROR, cleared only by err_clear in ERROR
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_err_illegal  <= 1'b0;
            r_err_datapath <= 1'b0;
        end else if (r_state == S_ERROR && bus.err_clear) begin
            r_err_illegal  <= 1'b0;
            r_err_datapath <= 1'b0;
        end else begin
            if (w_set_illegal)  r_err_illegal  <= 1'b1;
            if (w_set_datapath) r_err_datapath <= 1'b1;
        end
    end

    // Retired-instruction counter, wraps naturally at its width
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_count <= '0;
        else if (w_done) r_count <= r_count + 1'b1;
    end

    // A store retires in MEMORY, but a bad address means it never retires,
    // so its done pulse is gated by the address error seen that same cycle.
    assign w_done = (r_state == S_WRITEBACK) ||
                    (r_state == S_MEMORY && w_is_sw && !bus.mem_err_invalid_address);

    // Moore control outputs decoded from state and IR
    assign bus.instr_ready   = (r_state == S_FETCH);
    assign bus.rs_addr       = r_ir[25:21];
    assign bus.rt_addr       = r_ir[20:16];
    assign bus.imm           = r_ir[15:0];
    assign bus.alu_control   = (r_state == S_FETCH) ? ALU_ADD : w_alu_control;
    assign bus.alu_src_imm   = (r_state != S_FETCH) && w_alu_src_imm;
    assign bus.mem_to_reg    = (r_state != S_FETCH) && w_is_lw;
    assign bus.reg_write     = (r_state == S_WRITEBACK);
    assign bus.write_addr    = (r_state == S_WRITEBACK) ? w_write_addr : 5'd0;
    assign bus.mem_read      = (r_state == S_MEMORY) && w_is_lw;
    assign bus.mem_write     = (r_state == S_MEMORY) && w_is_sw;
    assign bus.instr_done    = w_done;
    assign bus.err_illegal   = r_err_illegal;
    assign bus.err_datapath  = r_err_datapath;
    assign bus.retired_count = r_count;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with a retire scoreboard (narrow counter to hit wrap).
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    localparam int CW = 2;

    typedef struct {
        int         lat;
        logic       we;
        logic [4:0] wa;
        logic       m2r;
        logic       src;
        logic [1:0] alu;
        logic       lw;
        logic       sw;
    } exp_t;

    logic clock;
    logic reset_n;
    int   n_checks;
    int   n_errors;
    int   exp_count;
    exp_t sb[$];

    multicycle_control_if #(.COUNT_WIDTH(CW)) bus();

    multicycle_control #(.COUNT_WIDTH(CW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    function automatic logic [31:0] cnt_exp();
        return 32'(exp_count % (1 << CW));
    endfunction

    // Independent reference: what a retiring instruction must look like
    function automatic exp_t model(input logic [31:0] ins);
        exp_t e;
        e.lat = 3; e.we = 1'b1; e.wa = ins[20:16]; e.m2r = 1'b0;
        e.src = 1'b1; e.alu = ALU_ADD; e.lw = 1'b0; e.sw = 1'b0;
        if (ins[31:26] == OP_RTYPE) begin
            e.src = 1'b0;
            e.wa  = ins[15:11];
            case (ins[5:0])
                FN_SUB:  e.alu = ALU_SUB;
                FN_AND:  e.alu = ALU_AND;
                FN_OR:   e.alu = ALU_OR;
                default: e.alu = ALU_ADD;
            endcase
        end else if (ins[31:26] == OP_LW) begin
            e.lat = 4; e.m2r = 1'b1; e.lw = 1'b1;
        end else if (ins[31:26] == OP_SW) begin
            e.we = 1'b0; e.wa = 5'd0; e.sw = 1'b1;
        end
        return e;
    endfunction

    // Issue one legal instruction and follow it to retirement
    task automatic do_instr(input logic [31:0] ins, input logic ovf);
        exp_t       e;
        int         c;
        int         rd_c;
        int         wr_c;
        logic       saw_we;
        logic [4:0] wa_seen;
        logic       done;
        chk("ready_before_accept", 32'(bus.instr_ready), 32'd1);
        bus.instr = ins;
        bus.instr_valid = 1'b1;
        bus.alu_err_overflow = ovf;
        sb.push_back(model(ins));
        step();
        bus.instr_valid = 1'b0;
        bus.instr = 32'hDEADBEEF;
        chk("decode_rs", 32'(bus.rs_addr), 32'(ins[25:21]));
        chk("decode_rt", 32'(bus.rt_addr), 32'(ins[20:16]));
        chk("decode_imm", 32'(bus.imm), 32'(ins[15:0]));
        chk("decode_waddr_zero", 32'(bus.write_addr), 32'd0);
        done = 1'b0; c = 1; rd_c = 0; wr_c = 0; saw_we = 1'b0; wa_seen = 5'd0;
        while (!done && c <= 8) begin
            if (bus.mem_read) rd_c = c;
            if (bus.mem_write) wr_c = c;
            if (bus.reg_write) begin saw_we = 1'b1; wa_seen = bus.write_addr; end
            if (bus.instr_done) done = 1'b1;
            else begin step(); c++; end
        end
        e = sb.pop_front();
        chk("retire_timeout", 32'(done), 32'd1);
        chk("latency", 32'(c), 32'(e.lat));
        chk("reg_write", 32'(saw_we), 32'(e.we));
        chk("write_addr", 32'(wa_seen), 32'(e.wa));
        chk("alu_control", 32'(bus.alu_control), 32'(e.alu));
        chk("alu_src_imm", 32'(bus.alu_src_imm), 32'(e.src));
        chk("mem_to_reg", 32'(bus.mem_to_reg), 32'(e.m2r));
        chk("mem_read_cycle", 32'(rd_c), e.lw ? 32'd3 : 32'd0);
        chk("mem_write_cycle", 32'(wr_c), e.sw ? 32'd3 : 32'd0);
        step();
        exp_count++;
        bus.alu_err_overflow = 1'b0;
        chk("done_one_cycle", 32'(bus.instr_done), 32'd0);
        chk("retired_count", 32'(bus.retired_count), cnt_exp());
    endtask

    // Issue an instruction expected to end in ERROR at cycle ecyc
    task automatic do_err(input logic [31:0] ins, input logic ovf, input logic merr,
                          input int ecyc, input logic eill, input logic edp);
        int   c;
        logic saw_we;
        logic saw_done;
        logic hit;
        chk("err_ready_before", 32'(bus.instr_ready), 32'd1);
        bus.instr = ins;
        bus.instr_valid = 1'b1;
        bus.alu_err_overflow = ovf;
        bus.mem_err_invalid_address = merr;
        step();
        bus.instr_valid = 1'b0;
        c = 1; saw_we = 1'b0; saw_done = 1'b0; hit = 1'b0;
        while (!hit && c <= 8) begin
            if (bus.reg_write) saw_we = 1'b1;
            if (bus.instr_done) saw_done = 1'b1;
            if (bus.err_illegal || bus.err_datapath) hit = 1'b1;
            else begin step(); c++; end
        end
        chk("err_timeout", 32'(hit), 32'd1);
        chk("err_cycle", 32'(c), 32'(ecyc));
        chk("err_illegal", 32'(bus.err_illegal), 32'(eill));
        chk("err_datapath", 32'(bus.err_datapath), 32'(edp));
        chk("err_no_reg_write", 32'(saw_we), 32'd0);
        chk("err_no_retire", 32'(saw_done), 32'd0);
        chk("err_ready_low", 32'(bus.instr_ready), 32'd0);
        bus.instr_valid = 1'b1;
        step(); step();
        bus.instr_valid = 1'b0;
        chk("err_sticky_ready", 32'(bus.instr_ready), 32'd0);
        chk("err_sticky_flag", 32'(bus.err_illegal | bus.err_datapath), 32'd1);
        chk("err_enables_off", 32'({bus.reg_write, bus.mem_read, bus.mem_write, bus.instr_done}), 32'd0);
        bus.err_clear = 1'b1;
        step();
        bus.err_clear = 1'b0;
        bus.alu_err_overflow = 1'b0;
        bus.mem_err_invalid_address = 1'b0;
        chk("clear_ready", 32'(bus.instr_ready), 32'd1);
        chk("clear_flags", 32'({bus.err_illegal, bus.err_datapath}), 32'd0);
        chk("clear_count_kept", 32'(bus.retired_count), cnt_exp());
    endtask

    initial begin
        n_checks = 0; n_errors = 0; exp_count = 0;
        reset_n = 1'b0;
        bus.instr = 32'd0; bus.instr_valid = 1'b0; bus.alu_err_overflow = 1'b0;
        bus.mem_err_invalid_address = 1'b0; bus.err_clear = 1'b0;
        step(); step();
        chk("rst_enables", 32'({bus.reg_write, bus.mem_read, bus.mem_write, bus.instr_done}), 32'd0);
        chk("rst_count", 32'(bus.retired_count), 32'd0);
        chk("rst_flags", 32'({bus.err_illegal, bus.err_datapath}), 32'd0);
        chk("rst_waddr", 32'(bus.write_addr), 32'd0);
        reset_n = 1'b1;
        step();
        chk("rst_ready", 32'(bus.instr_ready), 32'd1);

        do_instr(32'h00221820, 1'b0);   // add $3,$1,$2
        do_instr(32'h8C850008, 1'b0);   // lw $5,8($4)
        do_instr(32'hAC850004, 1'b0);   // sw $5,4($4)
        do_instr(32'h00221820, 1'b0);   // add back-to-back after sw
        do_instr(32'h20290005, 1'b0);   // addi $9,$1,5
        do_instr(32'h00223022, 1'b0);   // sub $6,$1,$2
        do_instr(32'h00223824, 1'b1);   // and with overflow high: must not trap
        do_instr(32'h00644025, 1'b0);   // or $8,$3,$4 (count wraps here)
        do_instr(32'h8C850008, 1'b1);   // lw with overflow high: must not trap
        do_instr(32'h00220020, 1'b0);   // add to $0 is still issued

        do_err(32'hFC000000, 1'b0, 1'b0, 2, 1'b1, 1'b0);  // opcode 0x3F
        do_err(32'h00221821, 1'b0, 1'b0, 2, 1'b1, 1'b0);  // R-type unknown funct
        do_err(32'h20290005, 1'b1, 1'b0, 3, 1'b0, 1'b1);  // addi overflow
        do_err(32'h8C850008, 1'b0, 1'b1, 4, 1'b0, 1'b1);  // lw bad address
        do_err(32'hAC850004, 1'b0, 1'b1, 4, 1'b0, 1'b1);  // sw bad address

        // Reset during EXECUTE of sub
        bus.instr = 32'h00223022;
        bus.instr_valid = 1'b1;
        step();
        bus.instr_valid = 1'b0;
        step();
        chk("pre_rst_alu_sub", 32'(bus.alu_control), 32'(ALU_SUB));
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_enables", 32'({bus.reg_write, bus.mem_read, bus.mem_write, bus.instr_done}), 32'd0);
        chk("midrst_count", 32'(bus.retired_count), 32'd0);
        chk("midrst_alu", 32'(bus.alu_control), 32'd0);
        chk("midrst_rs", 32'(bus.rs_addr), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        exp_count = 0;
        begin
            logic any_we;
            any_we = 1'b0;
            for (int i = 0; i < 4; i++) begin
                step();
                if (bus.reg_write) any_we = 1'b1;
            end
            chk("midrst_no_write", 32'(any_we), 32'd0);
        end

        for (int i = 0; i < 5; i++) do_instr(32'h00221820, 1'b0);
        chk("wrap_count_5", 32'(bus.retired_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
